// File: rtl/rpsc_input_filter_pkg.sv
// Shared constants and types for the RPSC interlock input filter.
// Defaults match the production card; benches override through parameters.
package rpsc_pkg;

    localparam int CHANNELS    = 8;
    localparam int PRESCALE    = 1000;
    localparam int DEBOUNCE    = 8;
    localparam int CHATTER_WIN = 256;
    localparam int CHATTER_MAX = 4;

    typedef logic [CHANNELS-1:0] chan_vec_t;

endpackage

// File: rtl/rpsc_input_filter_if.sv
// Field-side bundle of the interlock filter: raw contacts in, clean levels and diagnostics out.
interface rpsc_input_filter_if #(
    parameter int CHANNELS = rpsc_pkg::CHANNELS
);

    logic [CHANNELS-1:0] raw_in;
    logic                chatter_clr;
    logic [CHANNELS-1:0] filt_out;
    logic [CHANNELS-1:0] chatter;
    logic                tick;

    modport master (
        output raw_in,
        output chatter_clr,
        input  filt_out,
        input  chatter,
        input  tick
    );

    modport slave (
        input  raw_in,
        input  chatter_clr,
        output filt_out,
        output chatter,
        output tick
    );

endinterface

// File: rtl/rpsc_debounce_chan.sv
// One interlock channel: two-flop synchroniser, tick-based debounce and
// windowed transition counter driving a sticky chatter flag.
module rpsc_debounce_chan #(
    parameter int DEBOUNCE    = rpsc_pkg::DEBOUNCE,
    parameter int CHATTER_MAX = rpsc_pkg::CHATTER_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    input  logic win_end,
    input  logic chatter_clr,
    output logic filt,
    output logic chatter
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(CHATTER_MAX + 1);

    logic          sync1;
    logic          s;
    logic          prev;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] tr_cnt;
    logic          trans;
    logic          chat_set;

    assign trans = s ^ prev;
    // Any transition that lands the count on (or keeps it at) the limit qualifies,
    // so a flag cleared while saturated re-arms on the next edge of the contact.
    assign chat_set = tick && !win_end && trans && (tr_cnt >= TW'(CHATTER_MAX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt   <= 1'b0;
            db_cnt <= '0;
        end else if (tick) begin
            if (s == filt) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE - 1)) begin
                filt   <= s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev   <= 1'b0;
            tr_cnt <= '0;
        end else if (tick) begin
            prev <= s;
            if (win_end) begin
                tr_cnt <= trans ? TW'(1) : '0;
            end else if (trans && (tr_cnt != TW'(CHATTER_MAX))) begin
                tr_cnt <= tr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chatter <= 1'b0;
        end else if (chatter_clr) begin
            chatter <= 1'b0;
        end else if (chat_set) begin
            chatter <= 1'b1;
        end
    end

endmodule

// File: rtl/rpsc_input_filter.sv
// RPSC interlock input filter: shared sample prescaler and chatter window,
// one debounce/chatter channel per field contact.
module rpsc_input_filter #(
    parameter int CHANNELS    = rpsc_pkg::CHANNELS,
    parameter int PRESCALE    = rpsc_pkg::PRESCALE,
    parameter int DEBOUNCE    = rpsc_pkg::DEBOUNCE,
    parameter int CHATTER_WIN = rpsc_pkg::CHATTER_WIN,
    parameter int CHATTER_MAX = rpsc_pkg::CHATTER_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    rpsc_input_filter_if.slave   bus
);

    localparam int PW = $clog2(PRESCALE);
    localparam int WW = $clog2(CHATTER_WIN);

    logic [PW-1:0]       pre_cnt;
    logic                tick_q;
    logic [WW-1:0]       win_cnt;
    logic                win_end;
    logic [CHANNELS-1:0] filt_v;
    logic [CHANNELS-1:0] chat_v;

    // tick is registered one count early so it is high exactly while pre_cnt == PRESCALE-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == PW'(PRESCALE - 1)) ? '0 : pre_cnt + 1'b1;
            tick_q  <= (pre_cnt == PW'(PRESCALE - 2));
        end
    end

    assign win_end = tick_q && (win_cnt == WW'(CHATTER_WIN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
        end else if (tick_q) begin
            win_cnt <= win_end ? '0 : win_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        rpsc_debounce_chan #(
            .DEBOUNCE    (DEBOUNCE),
            .CHATTER_MAX (CHATTER_MAX)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .raw         (bus.raw_in[g]),
            .tick        (tick_q),
            .win_end     (win_end),
            .chatter_clr (bus.chatter_clr),
            .filt        (filt_v[g]),
            .chatter     (chat_v[g])
        );
    end

    assign bus.filt_out = filt_v;
    assign bus.chatter  = chat_v;
    assign bus.tick     = tick_q;

endmodule

// File: doc/rpsc_input_filter.md
# rpsc_input_filter

Qualifies raw interlock contacts (emergency stop, card position, air grid/anode, water flow, door, ground switch) for an RPSC card. Each of 8 asynchronous field inputs is synchronised, debounced on a prescaled sample tick and checked for contact chatter. The clean levels drive the per-channel fault latches' `in` pins directly. Chatter flags go to the card's diagnostic readback.

## Interface
- `CHANNELS`, 8, number of interlock inputs.
- `PRESCALE`, 1000, clk cycles per sample tick (≥2).
- `DEBOUNCE`, 8, consecutive differing ticks required to change a filtered level (≥1).
- `CHATTER_WIN`, 256, ticks per chatter observation window (≥2).
- `CHATTER_MAX`, 4, sampled transitions within one window that set a chatter flag (≥2).

Ports:
- `clk`  in  1  card clock.
- `reset`  in  1  asynchronous, active-high reset.
- `raw_in`  in  CHANNELS  field contacts, asynchronous; 1 = fault condition present.
- `chatter_clr`  in  1  one-cycle pulse; clears all chatter flags.
- `filt_out`  out  CHANNELS  debounced level per channel; feeds fault latch `in`.
- `chatter`  out  CHANNELS  sticky chatter flag per channel.
- `tick`  out  1  sample strobe, one clk wide; for diagnostics only.

## Operation
- **Reset:**
  - All sync flops, `filt_out`, `chatter`, `tick`, the prescaler and all counters go to 0.
  - The downstream latches share `reset`, so 0 is consistent with them.
- **Sync:** a two-flop synchroniser per bit produces `s[i]`. No other logic samples `raw_in`.
- **Prescaler:**
  - Counts 0..PRESCALE-1 and wraps to 0.
  - `tick` = 1 during the cycle the count equals PRESCALE-1.
- **Debounce (per channel, evaluated only on tick):**
  - If `s[i]` equals `filt_out[i]`: clear `db_cnt`.
  - Otherwise increment `db_cnt`.
  - When the increment reaches DEBOUNCE: `filt_out[i]` takes `s[i]` and `db_cnt` clears.
  - `db_cnt` width is $clog2(DEBOUNCE+1). It never exceeds DEBOUNCE.
- **Chatter window:**
  - A shared window counter advances on each tick, 0..CHATTER_WIN-1, then wraps.
  - The window-end tick is the one where the counter equals CHATTER_WIN-1.
- **Chatter count (per channel, evaluated only on tick):**
  - `prev[i]` holds `s[i]` from the previous tick.
  - A transition is a tick with `s[i]` ≠ `prev[i]`.
  - `tr_cnt` increments on each transition and saturates at CHATTER_MAX.
  - On the window-end tick, `tr_cnt` loads 1 if that tick is itself a transition, else 0.
  - When `tr_cnt` reaches CHATTER_MAX, `chatter[i]` sets.
- **Chatter flags:**
  - Sticky; only `chatter_clr` or `reset` clears them.
  - If `chatter_clr` and a set condition occur in the same cycle, clear wins.
  - The flag re-sets on a later qualifying transition.
- **Independence:** chatter does not inhibit or alter debounce. `filt_out` follows the debounce rule only.

## Timing
- Sync latency: 2 clk.
- Assertion latency:
  - Stable change to `filt_out` change: exactly DEBOUNCE ticks after the first tick that samples the new `s`.
  - Worst case: 2 + DEBOUNCE·PRESCALE clk.
- All outputs are registered. Updates happen on the clk edge that closes the tick cycle.
- `chatter_clr` takes effect on the next edge, regardless of tick.
- **Reset mid-operation:**
  - Takes effect asynchronously.
  - Release is synchronous to `clk`.
  - The first tick after release occurs PRESCALE cycles later.

## Structure
- Package `rpsc_pkg`:
  - Default parameter constants.
  - `typedef logic [CHANNELS-1:0] chan_vec_t`.
- Sub-module `rpsc_debounce_chan`:
  - One channel: synchroniser, `db_cnt`, `prev`, `tr_cnt`, chatter flag.
  - Inputs: `tick`, `win_end`, `chatter_clr`.
  - Instantiated CHANNELS times by generate.
- Top level holds the prescaler, window counter and port packing.

## Test plan
Bench parameters: PRESCALE=4, DEBOUNCE=3, CHATTER_WIN=16, CHATTER_MAX=3.
- **Reset:** hold `reset` with `raw_in`=8'hFF → all outputs 0. Release → `filt_out`=8'hFF at exactly 2+12 clk (±tick phase); no chatter.
- **Glitch rejection:** pulse `raw_in[0]` high for 2 ticks, then low → `filt_out[0]` stays 0; `db_cnt` clears.
- **Debounce:** hold `raw_in[3]` high for 3 ticks → `filt_out[3]`=1 on the 3rd tick edge. Other bits stay unchanged.
- **Chatter set:** toggle `raw_in[5]` every tick, 3 transitions within one window → `chatter[5]`=1. `filt_out[5]` stays 0.
- **Chatter window wrap:** 2 transitions at ticks 13–14, then 1 at tick 17 → no chatter. Transition on the window-end tick → new window starts with count 1.
- **Clear precedence:** `chatter_clr` coincident with a 3rd transition → `chatter`=0. Next qualifying transition → re-sets. Assert `reset` mid-debounce → immediate all-zero outputs.
